mem_bus_arbiter: RTL and testbench

//   Shares the single-port 4-bit data memory between the instruction-fetch path
//   (driven by control_unit's IR load sequence) and the load/store datapath.

---
 rtl/cpu_bus_pkg.sv | 5 +
 rtl/mem_bus_arbiter_if.sv | 14 +
 rtl/bus_wait_timer.sv | 15 +
 rtl/mem_bus_arbiter.sv | 77 +++++++
 tb/tb_mem_bus_arbiter.sv | 135 +++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared FSM state and bus owner encodings for the memory bus arbiter
package cpu_bus_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch, data and memory-side signals of the shared memory bus
interface mem_bus_arbiter_if #(parameter int ADDR_W = 4, parameter int DATA_W = 4);
  logic hold, if_req, if_gnt, if_done;
  logic dm_req, dm_we, dm_gnt, dm_done;
  logic mem_en, mem_we, busy;
  logic [ADDR_W-1:0] if_addr, dm_addr, mem_addr;
  logic [DATA_W-1:0] dm_wdata, rdata, mem_wdata, mem_rdata;
  modport slave(input hold, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
                output if_gnt, if_done, dm_gnt, dm_done, rdata, mem_en, mem_we, mem_addr,
                mem_wdata, busy);
  modport master(output hold, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
                 input if_gnt, if_done, dm_gnt, dm_done, rdata, mem_en, mem_we, mem_addr,
                 mem_wdata, busy);
endinterface

// File: rtl/bus_wait_timer.sv
// bus_wait_timer: loadable down-counter flagging the last cycle of a memory access
module bus_wait_timer #(parameter int W = 2) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         last
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= load ? load_val : (en && cnt != '0) ? cnt - 1'b1 : cnt;
  assign last = cnt == '0;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between fetch and data paths, data first with fetch starvation guard
module mem_bus_arbiter import cpu_bus_pkg::*; #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 4,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 2
) (
  input  logic clk,
  input  logic reset,
  mem_bus_arbiter_if.slave bus
);
  localparam int WW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  state_t state;
  owner_t owner;
  logic [SW-1:0] starve_cnt;
  logic arb, pick_if, last;
  always_comb begin
    arb     = state == S_IDLE && !bus.hold && (bus.if_req || bus.dm_req);
    pick_if = bus.if_req && (!bus.dm_req || starve_cnt == STARVE_MAX);
  end
  bus_wait_timer #(.W(WW)) u_timer (
    .clk(clk), .reset(reset), .load(arb), .en(state == S_ACCESS),
    .load_val(WW'(MEM_LAT - 1)), .last(last)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= S_IDLE;
      owner         <= OWN_IF;
      starve_cnt    <= '0;
      bus.if_gnt    <= 1'b0;
      bus.if_done   <= 1'b0;
      bus.dm_gnt    <= 1'b0;
      bus.dm_done   <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rdata     <= '0;
    end else begin
      bus.if_gnt  <= 1'b0;
      bus.dm_gnt  <= 1'b0;
      bus.if_done <= 1'b0;
      bus.dm_done <= 1'b0;
      case (state)
        S_IDLE: if (arb) begin
          state         <= S_ACCESS;
          owner         <= pick_if ? OWN_IF : OWN_DM;
          bus.if_gnt    <= pick_if;
          bus.dm_gnt    <= !pick_if;
          bus.mem_en    <= 1'b1;
          bus.mem_we    <= !pick_if && bus.dm_we;
          bus.mem_addr  <= pick_if ? bus.if_addr : bus.dm_addr;
          bus.mem_wdata <= pick_if ? bus.mem_wdata : bus.dm_wdata;
          bus.busy      <= 1'b1;
          // a fetch passed over counts toward forcing the next grant its way
          starve_cnt    <= (pick_if || !bus.if_req) ? '0 :
                           (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 1'b1;
        end
        S_ACCESS: if (last) begin
          state       <= S_RESP;
          bus.mem_en  <= 1'b0;
          bus.mem_we  <= 1'b0;
          bus.rdata   <= bus.mem_we ? bus.rdata : bus.mem_rdata;
          bus.if_done <= owner == OWN_IF;
          bus.dm_done <= owner == OWN_DM;
        end
        S_RESP: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven and sequence checks of the memory bus arbiter
module tb_mem_bus_arbiter;
  typedef struct packed {
    logic       hold, if_req;
    logic [3:0] if_addr;
    logic       dm_req, dm_we;
    logic [3:0] dm_addr, dm_wdata, mem_rdata;
    logic [6:0] flags;
    logic [3:0] addr, wdata, rdata;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[14];
  mem_bus_arbiter_if bus();
  mem_bus_arbiter dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [6:0] flags();
    return {bus.if_gnt, bus.if_done, bus.dm_gnt, bus.dm_done, bus.mem_en, bus.mem_we, bus.busy};
  endfunction
  function automatic logic [18:0] all_out();
    return {flags(), bus.mem_addr, bus.mem_wdata, bus.rdata};
  endfunction
  task automatic set_in(input logic h, input logic ir, input logic [3:0] ia, input logic dr,
                        input logic dw, input logic [3:0] da, input logic [3:0] dd,
                        input logic [3:0] mr);
    bus.hold = h; bus.if_req = ir; bus.if_addr = ia; bus.dm_req = dr;
    bus.dm_we = dw; bus.dm_addr = da; bus.dm_wdata = dd; bus.mem_rdata = mr;
  endtask
  task automatic run_order(input string tag);
    logic [5:0] order;
    int k, cyc;
    order = 6'b011011;
    k = 0;
    cyc = 0;
    set_in(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 4'h2, 4'h0, 4'h0);
    while (k < 6 && cyc < 60) begin
      step();
      cyc++;
      chk($sformatf("%s onehot", tag), {31'd0, $countones({bus.if_gnt, bus.if_done, bus.dm_gnt, bus.dm_done}) <= 1}, 1);
      if (bus.if_gnt || bus.dm_gnt) begin
        chk($sformatf("%s grant%0d is_dm", tag, k), bus.dm_gnt, order[k]);
        k++;
      end
    end
    chk($sformatf("%s grants seen", tag), k, 6);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    repeat (4) step();
  endtask
  initial begin
    int cyc;
    tbl[0]  = '{1'b0,1'b1,4'h5,1'b0,1'b0,4'h0,4'h0,4'hA,7'b1000101,4'h5,4'h0,4'h0};
    tbl[1]  = '{1'b0,1'b0,4'h5,1'b0,1'b0,4'h0,4'h0,4'hA,7'b0000101,4'h5,4'h0,4'h0};
    tbl[2]  = '{1'b0,1'b0,4'h5,1'b0,1'b0,4'h0,4'h0,4'hA,7'b0100001,4'h5,4'h0,4'hA};
    tbl[3]  = '{1'b0,1'b0,4'h0,1'b0,1'b0,4'h0,4'h0,4'h0,7'b0000000,4'h5,4'h0,4'hA};
    tbl[4]  = '{1'b0,1'b1,4'h9,1'b1,1'b1,4'h3,4'h6,4'hF,7'b0010111,4'h3,4'h6,4'hA};
    tbl[5]  = '{1'b0,1'b1,4'h9,1'b0,1'b0,4'h0,4'h0,4'hF,7'b0000111,4'h3,4'h6,4'hA};
    tbl[6]  = '{1'b0,1'b1,4'h9,1'b0,1'b0,4'h0,4'h0,4'hF,7'b0001001,4'h3,4'h6,4'hA};
    tbl[7]  = '{1'b0,1'b1,4'h9,1'b0,1'b0,4'h0,4'h0,4'hF,7'b0000000,4'h3,4'h6,4'hA};
    tbl[8]  = '{1'b0,1'b1,4'h9,1'b0,1'b0,4'h0,4'h0,4'hC,7'b1000101,4'h9,4'h6,4'hA};
    tbl[9]  = '{1'b0,1'b0,4'h0,1'b0,1'b0,4'h0,4'h0,4'hC,7'b0000101,4'h9,4'h6,4'hA};
    tbl[10] = '{1'b0,1'b0,4'h0,1'b0,1'b0,4'h0,4'h0,4'hC,7'b0100001,4'h9,4'h6,4'hC};
    tbl[11] = '{1'b0,1'b0,4'h0,1'b0,1'b0,4'h0,4'h0,4'h0,7'b0000000,4'h9,4'h6,4'hC};
    tbl[12] = '{1'b1,1'b1,4'h2,1'b1,1'b0,4'h7,4'h0,4'h0,7'b0000000,4'h9,4'h6,4'hC};
    tbl[13] = '{1'b0,1'b0,4'h0,1'b0,1'b0,4'h0,4'h0,4'h0,7'b0000000,4'h9,4'h6,4'hC};
    set_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    repeat (4) begin
      set_in(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
             4'($urandom), 4'($urandom));
      step();
      chk("reset outputs", {13'd0, all_out()}, 0);
    end
    set_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    reset = 1'b1;
    repeat (3) begin
      step();
      chk("idle after reset busy", bus.busy, 0);
    end
    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].hold, tbl[i].if_req, tbl[i].if_addr, tbl[i].dm_req, tbl[i].dm_we,
             tbl[i].dm_addr, tbl[i].dm_wdata, tbl[i].mem_rdata);
      step();
      chk($sformatf("row%0d flags", i), flags(), tbl[i].flags);
      chk($sformatf("row%0d mem_addr", i), bus.mem_addr, tbl[i].addr);
      chk($sformatf("row%0d mem_wdata", i), bus.mem_wdata, tbl[i].wdata);
      chk($sformatf("row%0d rdata", i), bus.rdata, tbl[i].rdata);
    end
    run_order("order");
    set_in(1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 4'h4, 4'h2, 4'h0);
    cyc = 0;
    do begin step(); cyc++; end while (!(bus.if_gnt || bus.dm_gnt) && cyc < 10);
    chk("hold dm first", bus.dm_gnt, 1);
    bus.hold = 1'b1;
    cyc = 0;
    do begin step(); cyc++; end while (!bus.dm_done && cyc < 10);
    chk("hold dm_done", bus.dm_done, 1);
    repeat (5) begin
      step();
      chk("hold no grant", {bus.if_gnt, bus.dm_gnt}, 0);
    end
    chk("hold busy", bus.busy, 0);
    bus.hold = 1'b0;
    step();
    chk("hold release gnt", bus.dm_gnt, 1);
    step();
    chk("abort mem_en before", bus.mem_en, 1);
    reset = 1'b0;
    #1;
    chk("abort outputs", {13'd0, all_out()}, 0);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (6) begin
      step();
      chk("abort no done", {bus.if_done, bus.dm_done, bus.busy}, 0);
    end
    run_order("post reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
